branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
Control-hazard sequencer for the 5-stage RV32I pipeline. It predicts conditional-branch direction in ID from a 2-bit saturating-counter table and redirects fetch early for predicted-taken branches and JAL. It resolves branches, JAL and JALR in EX using the branch decision, issues the PC redirect and IF/ID and ID/EX flushes, and holds the redirect until fetch accepts it. Two performance counters track resolved conditional branches and mispredictions.

Parameters:
ENTRIES, 64, number of prediction counters; power of 2, minimum 2
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  pipeline freeze; ID and EX do not advance
id_valid  in  1  valid instruction in ID
id_branch  in  1  ID instruction is a conditional branch
id_jump  in  1  ID instruction is JAL
id_pc  in  32  PC of the ID instruction
id_target  in  32  branch/JAL target computed in ID
id_pred_taken  out  1  prediction; carried down the pipe to ex_pred_taken
ex_valid  in  1  valid instruction in EX
ex_branch  in  1  EX instruction is a conditional branch
ex_jump  in  1  EX instruction is JAL
ex_jalr  in  1  EX instruction is JALR
ex_taken  in  1  actual branch outcome from the branch-condition logic
ex_pred_taken  in  1  prediction made for this instruction in ID
ex_pc  in  32  PC of the EX instruction
ex_target  in  32  resolved target (branch or JALR sum)
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  32  new fetch PC
fetch_ready  in  1  fetch accepts the redirect this cycle
flush_ifid  out  1  kill the IF/ID register
flush_idex  out  1  kill the ID/EX register
branch_cnt  out  CNT_W  resolved conditional branches
mispred_cnt  out  CNT_W  conditional mispredicts plus JALRs

Behaviour:
- Table index is pc[log2(ENTRIES)+1:2]. The read is asynchronous. Counters are updated on the clock edge. A same-cycle read and write to the same index returns the old value.
- id_pred_taken = id_valid & id_branch & ctr[idx(id_pc)][1].
- ex_fire = ex_valid & ~stall. id_fire = id_valid & ~stall.
- EX events, considered only on ex_fire:
  - Conditional mispredict: ex_branch & (ex_taken != ex_pred_taken). Redirect to ex_taken ? ex_target : ex_pc+4.
  - JALR: always redirects, to {ex_target[31:1],1'b0}.
  - JAL in EX: no action, because it was already redirected in ID.
  - Correct conditional prediction: no redirect.
- ID event, on id_fire with no EX event in the same cycle: if id_jump, or id_branch with a predicted-taken result, redirect to id_target.
- Priority: an EX event beats an ID event (EX is older; the ID instruction is wrong-path).
- Flushes:
  - EX event: assert flush_ifid and flush_idex.
  - ID event: assert flush_ifid only.
  - Flushes and redirect_valid are combinational in the event cycle.
- Counter update, on ex_fire & ex_branch:
  - ctr++ on taken, saturating at 3.
  - ctr-- on not taken, saturating at 0.
- Performance counters, on ex_fire:
  - branch_cnt += ex_branch.
  - mispred_cnt += (conditional mispredict | ex_jalr).
  - Both wrap modulo 2^CNT_W.
- State machine, IDLE / HOLD:
  - IDLE: if an event occurs and fetch_ready=0, latch redirect_pc and the event's flush_idex value, then go to HOLD. If fetch_ready=1, stay in IDLE.
  - HOLD: redirect_valid=1 and redirect_pc are registered values. flush_ifid=1 every cycle. flush_idex = latched value. New ID/EX events are ignored, since those stages hold only flushed bubbles. Return to IDLE on the cycle fetch_ready=1; redirect and flushes are still asserted in that cycle.
- stall=1 in IDLE: no events, no table or counter updates. Outputs other than id_pred_taken are 0.
- Reset, synchronous:
  - State goes to IDLE.
  - redirect_valid, flush_ifid, flush_idex go to 0; redirect_pc goes to 0.
  - Both performance counters go to 0.
  - All table counters go to 2'b01 (weakly not-taken).
  - Reset asserted while in HOLD abandons the pending redirect.

Test Plan:
- After reset, branch at id_pc=0x40: id_pred_taken=0. Resolve it in EX with ex_taken=1, ex_pred_taken=0, ex_target=0x80 -> redirect_pc=0x80, both flushes =1, ctr[16]=2, branch_cnt=1, mispred_cnt=1.
- Same branch resolved taken three more times -> ctr saturates at 3. Next ID lookup of 0x40 with id_target=0x80 -> id_pred_taken=1, redirect 0x80, flush_ifid=1, flush_idex=0. EX not-taken with ex_pred_taken=1 -> redirect 0x44, ctr=2.
- Same cycle: EX JALR with ex_target=0x1235 and ID JAL with target 0x200 -> redirect_pc=0x1234, both flushes, mispred_cnt +1, ID event dropped.
- EX mispredict with fetch_ready=0 for 3 cycles -> HOLD: redirect_valid=1 with a stable PC, flush_ifid=1 each cycle. fetch_ready=1 on the 4th cycle -> one more cycle asserted, then IDLE with outputs at 0.
- stall=1 with ex_valid=1 and a mispredict condition -> no redirect, no counter or table change. Release stall -> the event fires once.
- Reset asserted in HOLD -> next cycle redirect_valid=0, counters=0, ID lookup of any PC predicts not-taken. With CNT_W=4, 16 JALRs -> mispred_cnt wraps to 0.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Pipeline-side bundle for the branch redirect controller: ID/EX branch info in,
// fetch redirect, pipeline flushes and performance counters out.
interface branch_redirect_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             id_valid;
  logic             id_branch;
  logic             id_jump;
  logic [31:0]      id_pc;
  logic [31:0]      id_target;
  logic             id_pred_taken;
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_jalr;
  logic             ex_taken;
  logic             ex_pred_taken;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             fetch_ready;
  logic             flush_ifid;
  logic             flush_idex;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stall, id_valid, id_branch, id_jump, id_pc, id_target,
           ex_valid, ex_branch, ex_jump, ex_jalr, ex_taken, ex_pred_taken,
           ex_pc, ex_target, fetch_ready,
    input  id_pred_taken, redirect_valid, redirect_pc, flush_ifid, flush_idex,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall, id_valid, id_branch, id_jump, id_pc, id_target,
           ex_valid, ex_branch, ex_jump, ex_jalr, ex_taken, ex_pred_taken,
           ex_pc, ex_target, fetch_ready,
    output id_pred_taken, redirect_valid, redirect_pc, flush_ifid, flush_idex,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Control-hazard sequencer: 2-bit counter prediction in ID, resolution in EX,
// PC redirect with IF/ID and ID/EX flushes held until fetch accepts them.
module branch_redirect_ctrl #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_redirect_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ctr [ENTRIES];
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic [31:0]      r_hold_pc;
  logic             r_hold_idex;

  logic [IDX_W-1:0] w_id_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_pred;
  logic             w_idle;
  logic             w_ex_live;
  logic             w_mispred;
  logic             w_jalr;
  logic             w_ex_event;
  logic             w_id_event;
  logic [31:0]      w_event_pc;
  logic             w_latch;
  logic             w_redirect_valid;
  logic [31:0]      w_redirect_pc;
  logic             w_flush_ifid;
  logic             w_flush_idex;

  assign w_id_idx = bus.id_pc[IDX_W+1:2];
  assign w_ex_idx = bus.ex_pc[IDX_W+1:2];
  assign w_pred   = bus.id_valid & bus.id_branch & r_ctr[w_id_idx][1];

  // While holding a redirect, ID and EX carry only flushed bubbles.
  assign w_idle     = (r_state == IDLE);
  assign w_ex_live  = bus.ex_valid & ~bus.stall & w_idle;
  assign w_mispred  = w_ex_live & bus.ex_branch & (bus.ex_taken ^ bus.ex_pred_taken);
  assign w_jalr     = w_ex_live & bus.ex_jalr;
  assign w_ex_event = w_mispred | w_jalr;
  assign w_id_event = bus.id_valid & ~bus.stall & w_idle
                    & (bus.id_jump | w_pred) & ~w_ex_event;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_event_pc = 32'd0;
    if (w_mispred)
      w_event_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    else if (w_jalr)
      w_event_pc = {bus.ex_target[31:1], 1'b0};
    else if (w_id_event)
      w_event_pc = bus.id_target;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_latch          = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'd0;
    w_flush_ifid     = 1'b0;
    w_flush_idex     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ex_event || w_id_event) begin
          w_redirect_valid = 1'b1;
          w_redirect_pc    = w_event_pc;
          w_flush_ifid     = 1'b1;
          w_flush_idex     = w_ex_event;
          if (!bus.fetch_ready) begin
            w_latch     = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        w_redirect_valid = 1'b1;
        w_redirect_pc    = r_hold_pc;
        w_flush_ifid     = 1'b1;
        w_flush_idex     = r_hold_idex;
        if (bus.fetch_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_pc   <= 32'd0;
      r_hold_idex <= 1'b0;
    end else if (w_latch) begin
      r_hold_pc   <= w_event_pc;
      r_hold_idex <= w_ex_event;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter table is flop-based and must be reset so prediction starts weakly not-taken.
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (w_ex_live && bus.ex_branch) begin
      if (bus.ex_taken && r_ctr[w_ex_idx] != 2'b11)
        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
      else if (!bus.ex_taken && r_ctr[w_ex_idx] != 2'b00)
        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_ex_live) begin
      r_branch_cnt  <= r_branch_cnt + CNT_W'(bus.ex_branch);
      r_mispred_cnt <= r_mispred_cnt + CNT_W'(w_ex_event);
    end
  end

  assign bus.id_pred_taken  = w_pred;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.flush_ifid     = w_flush_ifid;
  assign bus.flush_idex     = w_flush_idex;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispred_cnt    = r_mispred_cnt;
endmodule
